rx_unit: RTL and testbench

Serial receive unit of the MiniUart: the stage that consumes the bit stream the transmit unit places on `txd`. Each frame is 1 start bit (0), 8 data bits LSB first and 1 stop bit (1), with an idle line held at 1. The block synchronises `rxd`, detects and validates the start bit with 16x oversampling, deserialises the byte and presents it on `d_out` with a ready flag. It also reports framing and overrun errors, and the host bus interface clears them with `rd_ack`.

---
 rtl/rx_unit_if.sv | 25 ++
 rtl/rx_unit.sv | 130 +++++++++++++
 tb/tb_rx_unit.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/rx_unit_if.sv
// Host-side signal bundle of the MiniUart receive unit: serial line, oversample tick,
// the received byte with its status flags, and a debug view of the FSM state.
interface rx_unit_if;
  logic       rxd;
  logic       en_rx;
  logic       rd_ack;
  logic [7:0] d_out;
  logic       rs;
  logic       fe;
  logic       oe;
  logic       busy;
  logic [2:0] dbg_state;

  // Handshake: rs=1 means d_out/fe hold a byte not yet taken; a one-cycle rd_ack
  // while rs=1 consumes it. rd_ack while rs=0 is ignored. There is no back-pressure.
  modport master (
    output rxd, en_rx, rd_ack,
    input  d_out, rs, fe, oe, busy, dbg_state
  );

  modport slave (
    input  rxd, en_rx, rd_ack,
    output d_out, rs, fe, oe, busy, dbg_state
  );
endinterface

// File: rtl/rx_unit.sv
// MiniUart receive unit: 8N1 deserialiser with 16x oversampling, start-bit
// validation, framing and overrun detection.
module rx_unit (
  input  logic       clk,
  input  logic       rst,
  rx_unit_if.slave   bus
);
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    STOP    = 3'd3,
    WAIT_HI = 3'd4
  } state_t;

  state_t     r_state, w_state_nxt;
  logic       r_sync1, r_sync2;
  logic       w_rxs;
  logic [3:0] r_os_cnt, w_os_nxt;
  logic [2:0] r_bit_cnt, w_bit_nxt;
  logic [7:0] r_sh_reg, w_sh_nxt;
  logic       w_done;
  logic [7:0] r_d_out;
  logic       r_rs, r_fe, r_oe;

  // Synchroniser resets to the idle level so reset never fakes a start bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= bus.rxd;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_os_cnt  <= 4'd0;
      r_bit_cnt <= 3'd0;
      r_sh_reg  <= 8'h00;
    end else begin
      r_state   <= w_state_nxt;
      r_os_cnt  <= w_os_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_sh_reg  <= w_sh_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_os_nxt    = r_os_cnt;
    w_bit_nxt   = r_bit_cnt;
    w_sh_nxt    = r_sh_reg;
    w_done      = 1'b0;
    if (bus.en_rx) begin
      case (r_state)
        IDLE: begin
          if (!w_rxs) begin
            w_state_nxt = START;
            w_os_nxt    = 4'd0;
          end
        end
        START: begin
          if (r_os_cnt == 4'd7) begin
            w_state_nxt = w_rxs ? IDLE : DATA;
            w_os_nxt    = 4'd0;
            w_bit_nxt   = 3'd0;
          end else begin
            w_os_nxt = r_os_cnt + 4'd1;
          end
        end
        DATA: begin
          // Counting from the mid-start sample, os_cnt==15 lands mid-bit.
          if (r_os_cnt == 4'd15) begin
            w_sh_nxt = {w_rxs, r_sh_reg[7:1]};
            w_os_nxt = 4'd0;
            if (r_bit_cnt == 3'd7) w_state_nxt = STOP;
            else                   w_bit_nxt   = r_bit_cnt + 3'd1;
          end else begin
            w_os_nxt = r_os_cnt + 4'd1;
          end
        end
        STOP: begin
          if (r_os_cnt == 4'd15) begin
            w_done      = 1'b1;
            w_os_nxt    = 4'd0;
            w_state_nxt = w_rxs ? IDLE : WAIT_HI;
          end else begin
            w_os_nxt = r_os_cnt + 4'd1;
          end
        end
        WAIT_HI: begin
          if (w_rxs) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // A completing byte takes priority over a simultaneous read acknowledge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_d_out <= 8'h00;
      r_rs    <= 1'b0;
      r_fe    <= 1'b0;
      r_oe    <= 1'b0;
    end else if (w_done) begin
      r_d_out <= r_sh_reg;
      r_rs    <= 1'b1;
      r_fe    <= ~w_rxs;
      if (bus.rd_ack)  r_oe <= 1'b0;
      else if (r_rs)   r_oe <= 1'b1;
    end else if (bus.rd_ack && r_rs) begin
      r_rs <= 1'b0;
      r_fe <= 1'b0;
      r_oe <= 1'b0;
    end
  end

  assign bus.d_out     = r_d_out;
  assign bus.rs        = r_rs;
  assign bus.fe        = r_fe;
  assign bus.oe        = r_oe;
  assign bus.busy      = (r_state != IDLE);
  assign bus.dbg_state = r_state;
endmodule

// File: tb/tb_rx_unit.sv
// Self-checking bench for rx_unit: serial frames driven at 64 clk per bit,
// results compared with a frame-level model of the status flags.
module tb_rx_unit;
  logic clk = 1'b0;
  logic rst;
  rx_unit_if bus();

  rx_unit dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  logic [7:0] exp_d;
  logic       exp_rs, exp_fe, exp_oe;
  logic [7:0] exp_q[$];

  // Oversample tick: one clk in four, changed just after the rising edge.
  initial begin
    bus.en_rx = 1'b0;
    forever begin
      for (int k = 0; k < 4; k++) begin
        @(posedge clk);
        #1;
        bus.en_rx = (k == 3);
      end
    end
  end

  task automatic model_frame(input logic [7:0] b, input logic stop_bit, input logic ack_same);
    exp_oe = ack_same ? 1'b0 : (exp_oe | exp_rs);
    exp_d  = b;
    exp_rs = 1'b1;
    exp_fe = ~stop_bit;
  endtask

  task automatic model_ack();
    if (exp_rs) begin
      exp_rs = 1'b0;
      exp_fe = 1'b0;
      exp_oe = 1'b0;
    end
  endtask

  task automatic pulse_ack();
    @(negedge clk) bus.rd_ack = 1'b1;
    @(negedge clk) bus.rd_ack = 1'b0;
    model_ack();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit);
    logic [9:0] f;
    f = {stop_bit, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      @(negedge clk) bus.rxd = f[i];
      repeat (63) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.rxd = 1'b1;
    bus.rd_ack = 1'b0;
    exp_d = 8'h00; exp_rs = 1'b0; exp_fe = 1'b0; exp_oe = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.d_out !== 8'h00) $display("FAIL reset_d_out got %h exp 00", bus.d_out); else n_pass++;
    n_checks++; if ({bus.rs, bus.fe, bus.oe, bus.busy} !== 4'b0000) $display("FAIL reset_flags got %b exp 0000", {bus.rs, bus.fe, bus.oe, bus.busy}); else n_pass++;
    @(negedge clk) rst = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic test_normal();
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1, 1'b0);
    n_checks++; if (bus.d_out !== exp_d) $display("FAIL normal_d_out got %h exp %h", bus.d_out, exp_d); else n_pass++;
    n_checks++; if ({bus.rs, bus.fe, bus.oe} !== {exp_rs, exp_fe, exp_oe}) $display("FAIL normal_flags got %b exp %b", {bus.rs, bus.fe, bus.oe}, {exp_rs, exp_fe, exp_oe}); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL normal_busy got %b exp 0", bus.busy); else n_pass++;
    pulse_ack();
    n_checks++; if (bus.rs !== exp_rs) $display("FAIL normal_ack_rs got %b exp %b", bus.rs, exp_rs); else n_pass++;
  endtask

  task automatic test_false_start();
    logic seen_busy;
    seen_busy = 1'b0;
    @(negedge clk) bus.rxd = 1'b0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (bus.busy) seen_busy = 1'b1;
    end
    bus.rxd = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (bus.busy) seen_busy = 1'b1;
    end
    n_checks++; if (seen_busy !== 1'b1) $display("FAIL false_start_busy_pulse got %b exp 1", seen_busy); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL false_start_idle got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if ({bus.d_out, bus.rs} !== {exp_d, exp_rs}) $display("FAIL false_start_unchanged got %h/%b exp %h/%b", bus.d_out, bus.rs, exp_d, exp_rs); else n_pass++;
  endtask

  task automatic test_framing();
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0, 1'b0);
    repeat (160) @(negedge clk);
    n_checks++; if (bus.d_out !== exp_d) $display("FAIL framing_d_out got %h exp %h", bus.d_out, exp_d); else n_pass++;
    n_checks++; if ({bus.rs, bus.fe, bus.oe} !== {exp_rs, exp_fe, exp_oe}) $display("FAIL framing_flags got %b exp %b", {bus.rs, bus.fe, bus.oe}, {exp_rs, exp_fe, exp_oe}); else n_pass++;
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL framing_wait_hi got %b exp 1", bus.busy); else n_pass++;
    bus.rxd = 1'b1;
    repeat (20) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL framing_idle got %b exp 0", bus.busy); else n_pass++;
    n_checks++; if ({bus.d_out, bus.rs} !== {exp_d, exp_rs}) $display("FAIL framing_no_new got %h/%b exp %h/%b", bus.d_out, bus.rs, exp_d, exp_rs); else n_pass++;
    pulse_ack();
    n_checks++; if (bus.fe !== exp_fe) $display("FAIL framing_ack_fe got %b exp %b", bus.fe, exp_fe); else n_pass++;
  endtask

  task automatic test_overrun();
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1, 1'b0);
    n_checks++; if (bus.d_out !== exp_d) $display("FAIL overrun_d_out got %h exp %h", bus.d_out, exp_d); else n_pass++;
    n_checks++; if ({bus.rs, bus.fe, bus.oe} !== {exp_rs, exp_fe, exp_oe}) $display("FAIL overrun_flags got %b exp %b", {bus.rs, bus.fe, bus.oe}, {exp_rs, exp_fe, exp_oe}); else n_pass++;
    pulse_ack();
    n_checks++; if ({bus.rs, bus.fe, bus.oe} !== {exp_rs, exp_fe, exp_oe}) $display("FAIL overrun_ack_flags got %b exp %b", {bus.rs, bus.fe, bus.oe}, {exp_rs, exp_fe, exp_oe}); else n_pass++;
  endtask

  task automatic test_simul_ack();
    logic found;
    found = 1'b0;
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1, 1'b0);
    fork
      send_frame(8'h22, 1'b1);
      begin
        for (int k = 0; k < 200; k++) begin
          @(negedge clk);
          if (bus.busy) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          // busy first seen one cycle after the T0 tick; T152 is 608 cycles after T0.
          repeat (607) @(negedge clk);
          bus.rd_ack = 1'b1;
          @(negedge clk) bus.rd_ack = 1'b0;
        end
      end
    join
    model_frame(8'h22, 1'b1, 1'b1);
    n_checks++; if (found !== 1'b1) $display("FAIL simul_start_timeout got %b exp 1", found); else n_pass++;
    n_checks++; if (bus.d_out !== exp_d) $display("FAIL simul_d_out got %h exp %h", bus.d_out, exp_d); else n_pass++;
    n_checks++; if ({bus.rs, bus.fe, bus.oe} !== {exp_rs, exp_fe, exp_oe}) $display("FAIL simul_flags got %b exp %b", {bus.rs, bus.fe, bus.oe}, {exp_rs, exp_fe, exp_oe}); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    logic [7:0] want;
    pulse_ack();
    for (int n = 0; n < 8; n++) begin
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1);
      exp_q.push_back(b);
      model_frame(b, 1'b1, 1'b0);
      want = exp_q.pop_front();
      n_checks++; if (bus.d_out !== want) $display("FAIL b2b_d_out[%0d] got %h exp %h", n, bus.d_out, want); else n_pass++;
      n_checks++; if ({bus.rs, bus.fe, bus.oe} !== {exp_rs, exp_fe, exp_oe}) $display("FAIL b2b_flags[%0d] got %b exp %b", n, {bus.rs, bus.fe, bus.oe}, {exp_rs, exp_fe, exp_oe}); else n_pass++;
      if ($urandom_range(0, 1) == 1) pulse_ack();
    end
  endtask

  task automatic test_reset_mid();
    logic [9:0] f;
    pulse_ack();
    f = {1'b1, 8'hF0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      @(negedge clk) bus.rxd = f[i];
      repeat (63) @(negedge clk);
    end
    @(negedge clk) bus.rxd = f[5];
    repeat (32) @(negedge clk);
    n_checks++; if (bus.busy !== 1'b1) $display("FAIL mid_busy got %b exp 1", bus.busy); else n_pass++;
    rst = 1'b0;
    #1;
    exp_d = 8'h00; exp_rs = 1'b0; exp_fe = 1'b0; exp_oe = 1'b0;
    n_checks++; if (bus.d_out !== exp_d) $display("FAIL mid_reset_d_out got %h exp %h", bus.d_out, exp_d); else n_pass++;
    n_checks++; if ({bus.rs, bus.fe, bus.oe, bus.busy} !== 4'b0000) $display("FAIL mid_reset_flags got %b exp 0000", {bus.rs, bus.fe, bus.oe, bus.busy}); else n_pass++;
    bus.rxd = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1, 1'b0);
    n_checks++; if (bus.d_out !== exp_d) $display("FAIL post_reset_d_out got %h exp %h", bus.d_out, exp_d); else n_pass++;
    n_checks++; if ({bus.rs, bus.fe, bus.oe} !== {exp_rs, exp_fe, exp_oe}) $display("FAIL post_reset_flags got %b exp %b", {bus.rs, bus.fe, bus.oe}, {exp_rs, exp_fe, exp_oe}); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_normal();
    test_false_start();
    test_framing();
    test_overrun();
    test_simul_ack();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
